// File: rtl/axis_adder_pkg.sv
// Shared types and sizing for the axis_adder complex beamforming weighter.
// Optional saturation of the scaled result is enabled by AXIS_ADDER_SAT_EN.
package axis_adder_pkg;

    localparam int NUM_LANES   = 8;
    localparam int SAMPLE_W    = 16;
    localparam int WEIGHT_W    = 8;
    localparam int WEIGHT_FRAC = 7;
    localparam int NUM_CH      = 4;
    localparam int NUM_STREAMS = 2 * NUM_CH;
    localparam int DATA_W      = NUM_LANES * SAMPLE_W;
    localparam int KEEP_W      = DATA_W / 8;
    localparam int PROD_W      = SAMPLE_W + WEIGHT_W;
    localparam int SUM_W       = PROD_W + 1;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef logic signed [SUM_W-1:0]    sum_t;

    typedef struct packed {
        sample_t re;
        sample_t im;
    } cplx_sample_t;

    typedef enum logic [1:0] {
        CH00,
        CH01,
        CH20,
        CH21
    } ch_t;

`ifdef AXIS_ADDER_SAT_EN
    localparam sum_t Q_MAX = sum_t'(32767);
    localparam sum_t Q_MIN = -sum_t'(32768);
`endif

    // Floor-scale a full-precision sum back to a sample.
    function automatic sample_t scale_sample(input sum_t s);
        sum_t q;
        q = s >>> WEIGHT_FRAC;
`ifdef AXIS_ADDER_SAT_EN
        if (q > Q_MAX) begin
            return sample_t'(Q_MAX);
        end else if (q < Q_MIN) begin
            return sample_t'(Q_MIN);
        end
`endif
        return sample_t'(q);
    endfunction

endpackage

// File: rtl/axis_adder_cmul_lane.sv
// One lane of complex multiply by a Q1.7 weight, two pipeline stages.
// Stage 1 holds the partial products, stage 2 the scaled sums.
module cmul_lane
    import axis_adder_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  cplx_sample_t x,
    input  weight_t      w_re,
    input  weight_t      w_im,
    output cplx_sample_t y
);

    logic signed [PROD_W-1:0] p_rr;
    logic signed [PROD_W-1:0] p_ii;
    logic signed [PROD_W-1:0] p_ri;
    logic signed [PROD_W-1:0] p_ir;

    sum_t sum_re;
    sum_t sum_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (en) begin
            p_rr <= x.re * w_re;
            p_ii <= x.im * w_im;
            p_ri <= x.re * w_im;
            p_ir <= x.im * w_re;
        end
    end

    always_comb begin
        sum_re = sum_t'(p_rr) - sum_t'(p_ii);
        sum_im = sum_t'(p_ri) + sum_t'(p_ir);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (en) begin
            y.re <= scale_sample(sum_re);
            y.im <= scale_sample(sum_im);
        end
    end

endmodule

// File: rtl/axis_adder.sv
// Four-channel complex weighter between RF sample streams and S2MM DMA.
// Define AXIS_ADDER_SAT_EN to saturate results instead of wrapping.
module axis_adder
    import axis_adder_pkg::*;
(
    input  logic                clock,
    input  logic                resetn,

    input  logic [WEIGHT_W-1:0] bWeight00_real,
    input  logic [WEIGHT_W-1:0] bWeight00_imag,
    input  logic [WEIGHT_W-1:0] bWeight01_real,
    input  logic [WEIGHT_W-1:0] bWeight01_imag,
    input  logic [WEIGHT_W-1:0] bWeight20_real,
    input  logic [WEIGHT_W-1:0] bWeight20_imag,
    input  logic [WEIGHT_W-1:0] bWeight21_real,
    input  logic [WEIGHT_W-1:0] bWeight21_imag,

    input  logic [DATA_W-1:0]   s00_axis_real_tdata,
    input  logic                s00_axis_real_tvalid,
    input  logic                s00_axis_real_tlast,
    output logic                s00_axis_real_tready,
    input  logic [DATA_W-1:0]   s00_axis_imag_tdata,
    input  logic                s00_axis_imag_tvalid,
    input  logic                s00_axis_imag_tlast,
    output logic                s00_axis_imag_tready,
    input  logic [DATA_W-1:0]   s01_axis_real_tdata,
    input  logic                s01_axis_real_tvalid,
    input  logic                s01_axis_real_tlast,
    output logic                s01_axis_real_tready,
    input  logic [DATA_W-1:0]   s01_axis_imag_tdata,
    input  logic                s01_axis_imag_tvalid,
    input  logic                s01_axis_imag_tlast,
    output logic                s01_axis_imag_tready,
    input  logic [DATA_W-1:0]   s20_axis_real_tdata,
    input  logic                s20_axis_real_tvalid,
    input  logic                s20_axis_real_tlast,
    output logic                s20_axis_real_tready,
    input  logic [DATA_W-1:0]   s20_axis_imag_tdata,
    input  logic                s20_axis_imag_tvalid,
    input  logic                s20_axis_imag_tlast,
    output logic                s20_axis_imag_tready,
    input  logic [DATA_W-1:0]   s21_axis_real_tdata,
    input  logic                s21_axis_real_tvalid,
    input  logic                s21_axis_real_tlast,
    output logic                s21_axis_real_tready,
    input  logic [DATA_W-1:0]   s21_axis_imag_tdata,
    input  logic                s21_axis_imag_tvalid,
    input  logic                s21_axis_imag_tlast,
    output logic                s21_axis_imag_tready,

    output logic [DATA_W-1:0]   m00_axis_real_s2mm_tdata,
    output logic [KEEP_W-1:0]   m00_axis_real_s2mm_tkeep,
    output logic                m00_axis_real_s2mm_tvalid,
    output logic                m00_axis_real_s2mm_tlast,
    input  logic                m00_axis_real_s2mm_tready,
    output logic [DATA_W-1:0]   m00_axis_imag_s2mm_tdata,
    output logic [KEEP_W-1:0]   m00_axis_imag_s2mm_tkeep,
    output logic                m00_axis_imag_s2mm_tvalid,
    output logic                m00_axis_imag_s2mm_tlast,
    input  logic                m00_axis_imag_s2mm_tready,
    output logic [DATA_W-1:0]   m01_axis_real_s2mm_tdata,
    output logic [KEEP_W-1:0]   m01_axis_real_s2mm_tkeep,
    output logic                m01_axis_real_s2mm_tvalid,
    output logic                m01_axis_real_s2mm_tlast,
    input  logic                m01_axis_real_s2mm_tready,
    output logic [DATA_W-1:0]   m01_axis_imag_s2mm_tdata,
    output logic [KEEP_W-1:0]   m01_axis_imag_s2mm_tkeep,
    output logic                m01_axis_imag_s2mm_tvalid,
    output logic                m01_axis_imag_s2mm_tlast,
    input  logic                m01_axis_imag_s2mm_tready,
    output logic [DATA_W-1:0]   m20_axis_real_s2mm_tdata,
    output logic [KEEP_W-1:0]   m20_axis_real_s2mm_tkeep,
    output logic                m20_axis_real_s2mm_tvalid,
    output logic                m20_axis_real_s2mm_tlast,
    input  logic                m20_axis_real_s2mm_tready,
    output logic [DATA_W-1:0]   m20_axis_imag_s2mm_tdata,
    output logic [KEEP_W-1:0]   m20_axis_imag_s2mm_tkeep,
    output logic                m20_axis_imag_s2mm_tvalid,
    output logic                m20_axis_imag_s2mm_tlast,
    input  logic                m20_axis_imag_s2mm_tready,
    output logic [DATA_W-1:0]   m21_axis_real_s2mm_tdata,
    output logic [KEEP_W-1:0]   m21_axis_real_s2mm_tkeep,
    output logic                m21_axis_real_s2mm_tvalid,
    output logic                m21_axis_real_s2mm_tlast,
    input  logic                m21_axis_real_s2mm_tready,
    output logic [DATA_W-1:0]   m21_axis_imag_s2mm_tdata,
    output logic [KEEP_W-1:0]   m21_axis_imag_s2mm_tkeep,
    output logic                m21_axis_imag_s2mm_tvalid,
    output logic                m21_axis_imag_s2mm_tlast,
    input  logic                m21_axis_imag_s2mm_tready
);

    localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

    // Stream bit 2*ch is the real stream, 2*ch+1 the imag stream.
    logic [NUM_STREAMS-1:0] s_valid;
    logic [NUM_STREAMS-1:0] s_last;
    logic [NUM_STREAMS-1:0] m_ready;

    logic [NUM_CH-1:0][DATA_W-1:0]   s_re;
    logic [NUM_CH-1:0][DATA_W-1:0]   s_im;
    logic [NUM_CH-1:0][DATA_W-1:0]   o_re;
    logic [NUM_CH-1:0][DATA_W-1:0]   o_im;
    logic [NUM_CH-1:0][WEIGHT_W-1:0] w_re;
    logic [NUM_CH-1:0][WEIGHT_W-1:0] w_im;

    logic                   en;
    logic                   s1_valid;
    logic                   s2_valid;
    logic [NUM_STREAMS-1:0] s1_last;
    logic [NUM_STREAMS-1:0] s2_last;

    assign s_valid = {
        s21_axis_imag_tvalid, s21_axis_real_tvalid,
        s20_axis_imag_tvalid, s20_axis_real_tvalid,
        s01_axis_imag_tvalid, s01_axis_real_tvalid,
        s00_axis_imag_tvalid, s00_axis_real_tvalid
    };
    assign s_last = {
        s21_axis_imag_tlast, s21_axis_real_tlast,
        s20_axis_imag_tlast, s20_axis_real_tlast,
        s01_axis_imag_tlast, s01_axis_real_tlast,
        s00_axis_imag_tlast, s00_axis_real_tlast
    };
    assign m_ready = {
        m21_axis_imag_s2mm_tready, m21_axis_real_s2mm_tready,
        m20_axis_imag_s2mm_tready, m20_axis_real_s2mm_tready,
        m01_axis_imag_s2mm_tready, m01_axis_real_s2mm_tready,
        m00_axis_imag_s2mm_tready, m00_axis_real_s2mm_tready
    };

    assign s_re = {s21_axis_real_tdata, s20_axis_real_tdata,
                   s01_axis_real_tdata, s00_axis_real_tdata};
    assign s_im = {s21_axis_imag_tdata, s20_axis_imag_tdata,
                   s01_axis_imag_tdata, s00_axis_imag_tdata};
    assign w_re = {bWeight21_real, bWeight20_real,
                   bWeight01_real, bWeight00_real};
    assign w_im = {bWeight21_imag, bWeight20_imag,
                   bWeight01_imag, bWeight00_imag};

    // Whole pipe advances as one; tready is held low during reset.
    assign en = resetn & (~s2_valid | (&m_ready));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_last  <= '0;
            s2_last  <= '0;
        end else if (en) begin
            s1_valid <= &s_valid;
            s1_last  <= (&s_valid) ? s_last : '0;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
            cplx_sample_t x;
            cplx_sample_t y;

            assign x.re = s_re[c][l*SAMPLE_W +: SAMPLE_W];
            assign x.im = s_im[c][l*SAMPLE_W +: SAMPLE_W];

            cmul_lane u_lane (
                .clk   (clock),
                .rst_n (resetn),
                .en    (en),
                .x     (x),
                .w_re  (w_re[c]),
                .w_im  (w_im[c]),
                .y     (y)
            );

            assign o_re[c][l*SAMPLE_W +: SAMPLE_W] = y.re;
            assign o_im[c][l*SAMPLE_W +: SAMPLE_W] = y.im;
        end
    end

    assign {s21_axis_imag_tready, s21_axis_real_tready,
            s20_axis_imag_tready, s20_axis_real_tready,
            s01_axis_imag_tready, s01_axis_real_tready,
            s00_axis_imag_tready, s00_axis_real_tready} = {NUM_STREAMS{en}};

    assign {m21_axis_imag_s2mm_tvalid, m21_axis_real_s2mm_tvalid,
            m20_axis_imag_s2mm_tvalid, m20_axis_real_s2mm_tvalid,
            m01_axis_imag_s2mm_tvalid, m01_axis_real_s2mm_tvalid,
            m00_axis_imag_s2mm_tvalid, m00_axis_real_s2mm_tvalid}
        = {NUM_STREAMS{s2_valid}};

    assign {m21_axis_imag_s2mm_tlast, m21_axis_real_s2mm_tlast,
            m20_axis_imag_s2mm_tlast, m20_axis_real_s2mm_tlast,
            m01_axis_imag_s2mm_tlast, m01_axis_real_s2mm_tlast,
            m00_axis_imag_s2mm_tlast, m00_axis_real_s2mm_tlast} = s2_last;

    assign {m21_axis_imag_s2mm_tkeep, m21_axis_real_s2mm_tkeep,
            m20_axis_imag_s2mm_tkeep, m20_axis_real_s2mm_tkeep,
            m01_axis_imag_s2mm_tkeep, m01_axis_real_s2mm_tkeep,
            m00_axis_imag_s2mm_tkeep, m00_axis_real_s2mm_tkeep}
        = {NUM_STREAMS{KEEP_ALL}};

    assign m00_axis_real_s2mm_tdata = o_re[CH00];
    assign m00_axis_imag_s2mm_tdata = o_im[CH00];
    assign m01_axis_real_s2mm_tdata = o_re[CH01];
    assign m01_axis_imag_s2mm_tdata = o_im[CH01];
    assign m20_axis_real_s2mm_tdata = o_re[CH20];
    assign m20_axis_imag_s2mm_tdata = o_im[CH20];
    assign m21_axis_real_s2mm_tdata = o_re[CH21];
    assign m21_axis_imag_s2mm_tdata = o_im[CH21];

endmodule

// File: tb/tb_axis_adder.sv
// Self-checking bench for axis_adder: vector table plus scoreboarded streams.
// Expected values follow AXIS_ADDER_SAT_EN when it is defined.
module tb_axis_adder;

`ifdef AXIS_ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [3:0][127:0] re;
        logic [3:0][127:0] im;
        logic [7:0]        last;
    } beat_t;

    typedef struct {
        logic [15:0] xr, xi;
        logic [7:0]  wr, wi;
        logic [15:0] er_w, ei_w, er_s, ei_s;
    } vec_t;

    logic clock = 1'b0;
    logic resetn;

    logic [3:0][7:0]   w_re, w_im;
    logic [3:0][127:0] s_re, s_im;
    logic [7:0]        s_valid, s_last, s_ready;
    logic [3:0][127:0] m_re, m_im;
    logic [7:0][15:0]  m_keep;
    logic [7:0]        m_valid, m_last, m_ready;

    int    n_chk = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    beat_t cur_exp;
    bit    last_acc;
    logic [7:0] vhist;
    vec_t  vecs[7];

    always #5 clock = ~clock;

    axis_adder dut (
        .clock(clock), .resetn(resetn),
        .bWeight00_real(w_re[0]), .bWeight00_imag(w_im[0]),
        .bWeight01_real(w_re[1]), .bWeight01_imag(w_im[1]),
        .bWeight20_real(w_re[2]), .bWeight20_imag(w_im[2]),
        .bWeight21_real(w_re[3]), .bWeight21_imag(w_im[3]),
        .s00_axis_real_tdata(s_re[0]), .s00_axis_real_tvalid(s_valid[0]),
        .s00_axis_real_tlast(s_last[0]), .s00_axis_real_tready(s_ready[0]),
        .s00_axis_imag_tdata(s_im[0]), .s00_axis_imag_tvalid(s_valid[1]),
        .s00_axis_imag_tlast(s_last[1]), .s00_axis_imag_tready(s_ready[1]),
        .s01_axis_real_tdata(s_re[1]), .s01_axis_real_tvalid(s_valid[2]),
        .s01_axis_real_tlast(s_last[2]), .s01_axis_real_tready(s_ready[2]),
        .s01_axis_imag_tdata(s_im[1]), .s01_axis_imag_tvalid(s_valid[3]),
        .s01_axis_imag_tlast(s_last[3]), .s01_axis_imag_tready(s_ready[3]),
        .s20_axis_real_tdata(s_re[2]), .s20_axis_real_tvalid(s_valid[4]),
        .s20_axis_real_tlast(s_last[4]), .s20_axis_real_tready(s_ready[4]),
        .s20_axis_imag_tdata(s_im[2]), .s20_axis_imag_tvalid(s_valid[5]),
        .s20_axis_imag_tlast(s_last[5]), .s20_axis_imag_tready(s_ready[5]),
        .s21_axis_real_tdata(s_re[3]), .s21_axis_real_tvalid(s_valid[6]),
        .s21_axis_real_tlast(s_last[6]), .s21_axis_real_tready(s_ready[6]),
        .s21_axis_imag_tdata(s_im[3]), .s21_axis_imag_tvalid(s_valid[7]),
        .s21_axis_imag_tlast(s_last[7]), .s21_axis_imag_tready(s_ready[7]),
        .m00_axis_real_s2mm_tdata(m_re[0]), .m00_axis_real_s2mm_tkeep(m_keep[0]),
        .m00_axis_real_s2mm_tvalid(m_valid[0]), .m00_axis_real_s2mm_tlast(m_last[0]),
        .m00_axis_real_s2mm_tready(m_ready[0]),
        .m00_axis_imag_s2mm_tdata(m_im[0]), .m00_axis_imag_s2mm_tkeep(m_keep[1]),
        .m00_axis_imag_s2mm_tvalid(m_valid[1]), .m00_axis_imag_s2mm_tlast(m_last[1]),
        .m00_axis_imag_s2mm_tready(m_ready[1]),
        .m01_axis_real_s2mm_tdata(m_re[1]), .m01_axis_real_s2mm_tkeep(m_keep[2]),
        .m01_axis_real_s2mm_tvalid(m_valid[2]), .m01_axis_real_s2mm_tlast(m_last[2]),
        .m01_axis_real_s2mm_tready(m_ready[2]),
        .m01_axis_imag_s2mm_tdata(m_im[1]), .m01_axis_imag_s2mm_tkeep(m_keep[3]),
        .m01_axis_imag_s2mm_tvalid(m_valid[3]), .m01_axis_imag_s2mm_tlast(m_last[3]),
        .m01_axis_imag_s2mm_tready(m_ready[3]),
        .m20_axis_real_s2mm_tdata(m_re[2]), .m20_axis_real_s2mm_tkeep(m_keep[4]),
        .m20_axis_real_s2mm_tvalid(m_valid[4]), .m20_axis_real_s2mm_tlast(m_last[4]),
        .m20_axis_real_s2mm_tready(m_ready[4]),
        .m20_axis_imag_s2mm_tdata(m_im[2]), .m20_axis_imag_s2mm_tkeep(m_keep[5]),
        .m20_axis_imag_s2mm_tvalid(m_valid[5]), .m20_axis_imag_s2mm_tlast(m_last[5]),
        .m20_axis_imag_s2mm_tready(m_ready[5]),
        .m21_axis_real_s2mm_tdata(m_re[3]), .m21_axis_real_s2mm_tkeep(m_keep[6]),
        .m21_axis_real_s2mm_tvalid(m_valid[6]), .m21_axis_real_s2mm_tlast(m_last[6]),
        .m21_axis_real_s2mm_tready(m_ready[6]),
        .m21_axis_imag_s2mm_tdata(m_im[3]), .m21_axis_imag_s2mm_tkeep(m_keep[7]),
        .m21_axis_imag_s2mm_tvalid(m_valid[7]), .m21_axis_imag_s2mm_tlast(m_last[7]),
        .m21_axis_imag_s2mm_tready(m_ready[7])
    );

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lane(input int xr, input int xi,
                                         input int wr, input int wi,
                                         input bit im);
        int f;
        int q;
        f = im ? (xr * wi + xi * wr) : (xr * wr - xi * wi);
        q = f >>> 7;
        if (SAT) begin
            if (q > 32767) q = 32767;
            else if (q < -32768) q = -32768;
        end
        return q[15:0];
    endfunction

    function automatic beat_t model();
        beat_t b;
        int xr, xi, wr, wi;
        for (int c = 0; c < 4; c++) begin
            wr = int'($signed(w_re[c]));
            wi = int'($signed(w_im[c]));
            for (int l = 0; l < 8; l++) begin
                xr = int'($signed(s_re[c][l*16 +: 16]));
                xi = int'($signed(s_im[c][l*16 +: 16]));
                b.re[c][l*16 +: 16] = lane(xr, xi, wr, wi, 1'b0);
                b.im[c][l*16 +: 16] = lane(xr, xi, wr, wi, 1'b1);
            end
        end
        b.last = s_last;
        return b;
    endfunction

    // One clock: decide handshakes before the edge, score after it.
    task automatic cycle();
        bit    acc;
        bit    outv;
        beat_t got;
        beat_t e;
        #1;
        acc  = (s_ready == 8'hFF) && (s_valid == 8'hFF);
        outv = m_valid[0] && (m_ready == 8'hFF);
        got.re = m_re;
        got.im = m_im;
        got.last = m_last;
        vhist = {vhist[6:0], m_valid[0]};
        chk("lockstep", {(m_valid == 8'h00 || m_valid == 8'hFF),
                         (s_ready == 8'h00 || s_ready == 8'hFF)}, 2'b11);
        @(posedge clock);
        last_acc = acc;
        if (outv) begin
            chk("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int c = 0; c < 4; c++) begin
                    chk($sformatf("ch%0d_re", c), got.re[c], e.re[c]);
                    chk($sformatf("ch%0d_im", c), got.im[c], e.im[c]);
                end
                chk("tlast", got.last, e.last);
            end
        end
        if (acc) exp_q.push_back(cur_exp);
        #1;
    endtask

    task automatic new_beat();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) begin
                s_re[c][k*32 +: 32] = $urandom();
                s_im[c][k*32 +: 32] = $urandom();
            end
            w_re[c] = 8'($urandom());
            w_im[c] = 8'($urandom());
        end
        s_last = 8'($urandom());
        cur_exp = model();
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            if (last_acc) new_beat();
            s_valid = 8'hFF;
            cycle();
        end
    endtask

    task automatic drain();
        s_valid = 8'h00;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0][127:0] snap_re, snap_im;
        logic [7:0]        snap_last;

        vecs[0] = '{16'h00A0, 16'h00B0, 8'h7F, 8'h00,
                    16'h009E, 16'h00AE, 16'h009E, 16'h00AE};
        vecs[1] = '{16'h00C0, 16'h00D0, 8'h57, 8'hA4,
                    16'h0118, 16'h0003, 16'h0118, 16'h0003};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 8'h7F, 8'h80,
                    16'hFEFE, 16'hFF00, 16'h7FFF, 16'hFF00};
        vecs[3] = '{16'h0064, 16'hFF9C, 8'h80, 8'h00,
                    16'hFF9C, 16'h0064, 16'hFF9C, 16'h0064};
        vecs[4] = '{16'hFFFF, 16'h0001, 8'h01, 8'h00,
                    16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[5] = '{16'h8000, 16'h7FFF, 8'h80, 8'h80,
                    16'hFFFF, 16'h0001, 16'h7FFF, 16'h0001};
        vecs[6] = '{16'h8000, 16'h7FFF, 8'h7F, 8'h7F,
                    16'h0200, 16'hFFFF, 16'h8000, 16'hFFFF};

        resetn  = 1'b0;
        w_re    = '0;
        w_im    = '0;
        s_re    = '0;
        s_im    = '0;
        s_last  = '0;
        s_valid = 8'hFF;
        m_ready = 8'hFF;
        vhist   = '0;
        last_acc = 1'b1;

        // Reset state
        #12;
        chk("rst_tready", s_ready, 8'h00);
        chk("rst_tvalid", m_valid, 8'h00);
        chk("rst_tlast", m_last, 8'h00);
        chk("rst_tdata", {m_re, m_im} == '0, 1);
        chk("rst_tkeep", m_keep, {8{16'hFFFF}});
        s_valid = 8'h00;
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Fixed vectors on every channel and lane, with latency check
        for (int i = 0; i < 7; i++) begin
            s_re   = {32{vecs[i].xr}};
            s_im   = {32{vecs[i].xi}};
            w_re   = {4{vecs[i].wr}};
            w_im   = {4{vecs[i].wi}};
            s_last = 8'(1 << i);
            cur_exp.re   = {32{SAT ? vecs[i].er_s : vecs[i].er_w}};
            cur_exp.im   = {32{SAT ? vecs[i].ei_s : vecs[i].ei_w}};
            cur_exp.last = 8'(1 << i);
            s_valid = 8'hFF;
            cycle();
            s_valid = 8'h00;
            chk($sformatf("vec%0d_lat1", i), m_valid, 8'h00);
            cycle();
            chk($sformatf("vec%0d_lat2", i), m_valid, 8'hFF);
            cycle();
        end
        drain();

        // Backpressure on one output stream for 5 cycles
        last_acc = 1'b1;
        stream(4);
        m_ready[3] = 1'b0;
        snap_re = m_re;
        snap_im = m_im;
        snap_last = m_last;
        for (int k = 0; k < 5; k++) begin
            if (last_acc) new_beat();
            s_valid = 8'hFF;
            cycle();
            chk($sformatf("stall%0d_tready", k), s_ready, 8'h00);
            chk($sformatf("stall%0d_tvalid", k), m_valid, 8'hFF);
            chk($sformatf("stall%0d_data", k), {m_re, m_im}, {snap_re, snap_im});
            chk($sformatf("stall%0d_last", k), m_last, snap_last);
        end
        m_ready = 8'hFF;
        stream(4);
        drain();

        // Bubble from s20 imag and tlast on s21 third beat
        vhist = '0;
        for (int k = 0; k < 8; k++) begin
            if (last_acc) new_beat();
            s_last = (k == 3) ? 8'hC0 : 8'h00;
            cur_exp.last = s_last;
            s_valid = (k >= 6) ? 8'h00 : (k == 1) ? 8'hDF : 8'hFF;
            cycle();
        end
        chk("bubble_pattern", vhist, 8'b0010_1111);
        drain();

        // Reset pulse while streaming
        last_acc = 1'b1;
        stream(3);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_tvalid", m_valid, 8'h00);
        chk("arst_tdata", {m_re, m_im} == '0, 1);
        chk("arst_tready", s_ready, 8'h00);
        chk("arst_tlast", m_last, 8'h00);
        exp_q.delete();
        s_valid = 8'h00;
        @(posedge clock);
        #3;
        resetn = 1'b1;
        s_re   = {32{vecs[1].xr}};
        s_im   = {32{vecs[1].xi}};
        w_re   = {4{vecs[1].wr}};
        w_im   = {4{vecs[1].wi}};
        s_last = 8'h00;
        cur_exp.re   = {32{16'h0118}};
        cur_exp.im   = {32{16'h0003}};
        cur_exp.last = 8'h00;
        s_valid = 8'hFF;
        cycle();
        s_valid = 8'h00;
        chk("post_rst_lat1", m_valid, 8'h00);
        cycle();
        chk("post_rst_lat2", m_valid, 8'hFF);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
